// File: rtl/wb_trace_pkg.sv
// Shared constants and entry layout for the writeback trace buffer.
// Optional macro WB_TRACE_PC_EN adds the PC of the writing instruction to each entry.
package wb_trace_pkg;

  localparam int unsigned REG_W         = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam int unsigned ENTRY_W_BASE  = REG_W + DATA_W;          // 37
  localparam int unsigned ENTRY_W_PC    = REG_W + DATA_W + PC_W;   // 69

`ifdef WB_TRACE_PC_EN
  localparam int unsigned ENTRY_W = ENTRY_W_PC;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } traceEntry_t;
`else
  localparam int unsigned ENTRY_W = ENTRY_W_BASE;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } traceEntry_t;
`endif

  // Writes to $0 are architecturally invisible and never traced.
  function automatic logic isEvent(input logic regWrite, input logic [REG_W-1:0] rd);
    return regWrite && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic first-word-fall-through FIFO with separate occupancy counter.
// The head is read combinationally from storage; when empty the last popped word is presented.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DepthL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
  logic [PTR_W:0]   levelQ;
  logic [WIDTH-1:0] lastQ;
  logic             pushEn, popEn;

  assign empty  = (levelQ == '0);
  assign full   = (levelQ == DepthL);
  assign level  = levelQ;
  assign popEn  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign pushEn = push && (!full || popEn);
  assign rdata  = empty ? lastQ : mem[rdPtrQ];

  // Storage array: no reset needed, validity is tracked by levelQ.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtrQ] <= wdata;
    end
  end

  // Pointers, occupancy and last-popped word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      levelQ <= '0;
      lastQ  <= '0;
    end else begin
      if (pushEn) begin
        wrPtrQ <= wrPtrQ + PTR_W'(1);
      end
      if (popEn) begin
        rdPtrQ <= rdPtrQ + PTR_W'(1);
        lastQ  <= mem[rdPtrQ];
      end
      if (pushEn && !popEn) begin
        levelQ <= levelQ + 1'b1;
      end else if (popEn && !pushEn) begin
        levelQ <= levelQ - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: filters architectural register writes into a FWFT FIFO,
// counts accepted and dropped events, and flags overflow.
// Optional macro WB_TRACE_PC_EN adds PCW/TracePC and widens each entry to 69 bits.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     RegWriteW,
  input  logic [REG_W-1:0]         WriteRegW,
  input  logic [DATA_W-1:0]        WriteDataW,
`ifdef WB_TRACE_PC_EN
  input  logic [PC_W-1:0]          PCW,
  output logic [PC_W-1:0]          TracePC,
`endif
  output logic                     TraceValid,
  input  logic                     TraceReady,
  output logic [REG_W-1:0]         TraceReg,
  output logic [DATA_W-1:0]        TraceData,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow,
  input  logic                     ClearOverflow,
  output logic [CNT_W-1:0]         EventCount,
  output logic [CNT_W-1:0]         DropCount
);

  traceEntry_t      pushEntry, headEntry;
  logic             fifoFull, fifoEmpty;
  logic             evValid, popFire, spaceAvail, pushFire, dropFire;
  logic             overflowQ;
  logic [CNT_W-1:0] eventCountQ, dropCountQ;

  assign evValid    = isEvent(RegWriteW, WriteRegW);
  assign popFire    = !fifoEmpty && TraceReady;
  assign spaceAvail = !fifoFull || popFire;
  assign pushFire   = evValid && spaceAvail;
  assign dropFire   = evValid && !spaceAvail;

  // Pack the incoming writeback into an entry.
  always_comb begin
    pushEntry      = '0;
    pushEntry.rd   = WriteRegW;
    pushEntry.data = WriteDataW;
`ifdef WB_TRACE_PC_EN
    pushEntry.pc   = PCW;
`endif
  end

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .clk   (Clk),
    .rstN  (Reset),
    .push  (pushFire),
    .pop   (popFire),
    .wdata (pushEntry),
    .rdata (headEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (Level)
  );

  // Event and drop counters plus sticky overflow; a same-cycle drop beats a clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      eventCountQ <= '0;
      dropCountQ  <= '0;
      overflowQ   <= 1'b0;
    end else begin
      if (pushFire) begin
        eventCountQ <= eventCountQ + 1'b1;
      end
      if (dropFire) begin
        overflowQ <= 1'b1;
        if (ClearOverflow) begin
          dropCountQ <= CNT_W'(1);
        end else if (dropCountQ != '1) begin
          dropCountQ <= dropCountQ + 1'b1;
        end
      end else if (ClearOverflow) begin
        overflowQ  <= 1'b0;
        dropCountQ <= '0;
      end
    end
  end

  assign TraceValid = !fifoEmpty;
  assign TraceReg   = headEntry.rd;
  assign TraceData  = headEntry.data;
`ifdef WB_TRACE_PC_EN
  assign TracePC    = headEntry.pc;
`endif
  assign Overflow   = overflowQ;
  assign EventCount = eventCountQ;
  assign DropCount  = dropCountQ;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              RegWriteW = 1'b0;
  logic [4:0]        WriteRegW = '0;
  logic [31:0]       WriteDataW = '0;
  logic              TraceValid;
  logic              TraceReady = 1'b0;
  logic [4:0]        TraceReg;
  logic [31:0]       TraceData;
  logic [4:0]        Level;
  logic              Overflow;
  logic              ClearOverflow = 1'b0;
  logic [CNT_W-1:0]  EventCount;
  logic [CNT_W-1:0]  DropCount;
  logic [31:0]       PCW = '0;
`ifdef WB_TRACE_PC_EN
  logic [31:0]       TracePC;
`endif

  always #5 Clk = ~Clk;

  wb_trace_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .RegWriteW     (RegWriteW),
    .WriteRegW     (WriteRegW),
    .WriteDataW    (WriteDataW),
`ifdef WB_TRACE_PC_EN
    .PCW           (PCW),
    .TracePC       (TracePC),
`endif
    .TraceValid    (TraceValid),
    .TraceReady    (TraceReady),
    .TraceReg      (TraceReg),
    .TraceData     (TraceData),
    .Level         (Level),
    .Overflow      (Overflow),
    .ClearOverflow (ClearOverflow),
    .EventCount    (EventCount),
    .DropCount     (DropCount)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, counters are integers.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } evEntry_t;

  evEntry_t    mq[$];
  int unsigned mEvents;
  int unsigned mDrops;
  bit          mOvf;

  task automatic modelReset();
    mq.delete();
    mEvents = 0;
    mDrops  = 0;
    mOvf    = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    logic [CNT_W-1:0] expEv;
    expEv = CNT_W'(mEvents);
    checkEq({tag, ".level"}, 64'(Level), 64'(mq.size()));
    checkEq({tag, ".valid"}, 64'(TraceValid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkEq({tag, ".reg"}, 64'(TraceReg), 64'(mq[0].rd));
      checkEq({tag, ".data"}, 64'(TraceData), 64'(mq[0].data));
`ifdef WB_TRACE_PC_EN
      checkEq({tag, ".pc"}, 64'(TracePC), 64'(mq[0].pc));
`endif
    end
    checkEq({tag, ".events"}, 64'(EventCount), 64'(expEv));
    checkEq({tag, ".drops"}, 64'(DropCount), 64'(mDrops));
    checkEq({tag, ".ovf"}, 64'(Overflow), 64'(mOvf));
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input bit rw, input logic [4:0] rd,
                      input logic [31:0] data, input bit ready, input bit clr);
    int       sizeBefore;
    bit       ev, pop, space, drop;
    evEntry_t e;
    logic [31:0] pc;
    pc            = $urandom;
    RegWriteW     = rw;
    WriteRegW     = rd;
    WriteDataW    = data;
    PCW           = pc;
    TraceReady    = ready;
    ClearOverflow = clr;
    @(posedge Clk);
    sizeBefore = mq.size();
    ev    = rw && (rd != 0);
    pop   = (sizeBefore != 0) && ready;
    space = (sizeBefore < DEPTH) || pop;
    drop  = ev && !space;
    if (pop) void'(mq.pop_front());
    if (ev && space) begin
      e.rd = rd; e.data = data; e.pc = pc;
      mq.push_back(e);
      mEvents++;
    end
    if (drop) begin
      mOvf   = 1'b1;
      mDrops = clr ? 1 : ((mDrops >= 65535) ? 65535 : mDrops + 1);
    end else if (clr) begin
      mOvf   = 1'b0;
      mDrops = 0;
    end
    #1;
    checkAll(tag);
  endtask

  // Asynchronous 1 ns reset pulse placed mid-cycle.
  task automatic pulseReset();
    RegWriteW = 1'b0; TraceReady = 1'b0; ClearOverflow = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    checkEq("rst.level", 64'(Level), 64'd0);
    checkEq("rst.valid", 64'(TraceValid), 64'd0);
    checkEq("rst.events", 64'(EventCount), 64'd0);
    checkEq("rst.drops", 64'(DropCount), 64'd0);
    checkEq("rst.ovf", 64'(Overflow), 64'd0);
    checkEq("rst.reg", 64'(TraceReg), 64'd0);
    checkEq("rst.data", 64'(TraceData), 64'd0);
    Reset = 1'b1;
    modelReset();
    @(posedge Clk);
    #1;
    checkAll("postrst");
  endtask

  initial begin
    int readyPct;
    modelReset();
    #12;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkAll("init");
    checkEq("init.reg", 64'(TraceReg), 64'd0);

    // Mid-stream reset after five accepted events.
    for (int i = 1; i <= 5; i++) step("pre5", 1'b1, 5'(i), $urandom, 1'b0, 1'b0);
    pulseReset();

    // Single event becomes visible one edge later.
    step("single", 1'b1, 5'd8, 32'h0000_0005, 1'b0, 1'b0);
    checkEq("single.reg", 64'(TraceReg), 64'd8);
    checkEq("single.data", 64'(TraceData), 64'd5);
    checkEq("single.level", 64'(Level), 64'd1);
    checkEq("single.events", 64'(EventCount), 64'd1);

    // Writes to $0 are ignored entirely.
    step("zero", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkEq("zero.level", 64'(Level), 64'd1);
    checkEq("zero.events", 64'(EventCount), 64'd1);
    checkEq("zero.drops", 64'(DropCount), 64'd0);

    // Fill past capacity.
    pulseReset();
    for (int r = 1; r <= 18; r++) step("fill", 1'b1, 5'(r), 32'(r * 3), 1'b0, 1'b0);
    checkEq("fill.level", 64'(Level), 64'd16);
    checkEq("fill.ovf", 64'(Overflow), 64'd1);
    checkEq("fill.drops", 64'(DropCount), 64'd2);
    checkEq("fill.events", 64'(EventCount), 64'd16);
    checkEq("fill.head", 64'(TraceReg), 64'd1);

    // Push and pop together while full.
    step("fullpp", 1'b1, 5'd20, 32'h14, 1'b1, 1'b0);
    checkEq("fullpp.level", 64'(Level), 64'd16);
    checkEq("fullpp.drops", 64'(DropCount), 64'd2);

    // Drain: regs 2..16 with data reg*3, then reg 20 last.
    for (int k = 0; k < 16; k++) begin
      checkEq("drain.reg", 64'(TraceReg), (k < 15) ? 64'(k + 2) : 64'd20);
      checkEq("drain.data", 64'(TraceData), (k < 15) ? 64'((k + 2) * 3) : 64'h14);
      step("drain", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    end
    checkEq("drain.empty", 64'(TraceValid), 64'd0);
    checkEq("drain.hold", 64'(TraceReg), 64'd20);

    // Clear versus drop in the same cycle.
    for (int r = 1; r <= 16; r++) step("refill", 1'b1, 5'(r), 32'(r), 1'b0, 1'b0);
    step("clrdrop", 1'b1, 5'd5, 32'd7, 1'b0, 1'b1);
    checkEq("clrdrop.ovf", 64'(Overflow), 64'd1);
    checkEq("clrdrop.drops", 64'(DropCount), 64'd1);
    step("clr", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkEq("clr.ovf", 64'(Overflow), 64'd0);
    checkEq("clr.drops", 64'(DropCount), 64'd0);

    // Randomized traffic with varying consumer throughput.
    pulseReset();
    for (int blk = 0; blk < 6; blk++) begin
      readyPct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 90 : 50);
      for (int i = 0; i < 80; i++) begin
        step("rand",
             ($urandom % 4) != 0,
             (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
             $urandom,
             ($urandom % 100) < readyPct,
             ($urandom % 40) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Receiver for the pipeline's writeback port. It captures every architectural register write (WriteRegW, WriteDataW, gated by RegWriteW) into a FIFO.
- A consumer (bench checker or debug UART bridge) drains the FIFO over a valid/ready stream.
- Sits beside top2, fed from the W-stage signals; replaces waveform-only inspection of writeback with a checkable event stream.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the event and drop counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RegWriteW  in  1  a writeback occurs this cycle.
- WriteRegW  in  5  destination register number.
- WriteDataW  in  32  value written.
- TraceValid  out  1  head entry available.
- TraceReady  in  1  consumer accepts the head entry.
- TraceReg  out  5  head entry register number.
- TraceData  out  32  head entry data.
- Level  out  $clog2(DEPTH)+1  current occupancy.
- Overflow  out  1  sticky: at least one event was dropped.
- ClearOverflow  in  1  synchronous clear of Overflow and DropCount.
- EventCount  out  CNT_W  accepted events, wraps modulo 2^CNT_W.
- DropCount  out  CNT_W  dropped events, saturates at all-ones.

Behaviour:
- Reset low, asynchronously: FIFO empty, rd/wr pointers 0, TraceValid=0, TraceReg=0, TraceData=0, Level=0, Overflow=0, EventCount=0, DropCount=0. Any event in flight is lost; nothing is accepted while Reset is low.
- Event definition: RegWriteW=1 and WriteRegW!=0. Writes to $0 are ignored and are counted neither as events nor as drops.
- Push: an event with space available is written at wr pointer, and EventCount increments.
- Space available: Level<DEPTH, or Level==DEPTH with a pop in the same cycle. Push and pop in the same cycle when full is legal and Level stays DEPTH.
- Drop: an event with no space available. Set Overflow and increment DropCount (saturating); EventCount does not change.
- Pop: TraceValid and TraceReady both 1 at the rising edge. The rd pointer advances and Level decrements, unless a simultaneous push keeps Level unchanged.
- Output timing: first-word-fall-through. TraceReg/TraceData reflect the head entry combinationally from registered storage.
  - TraceValid=(Level!=0).
  - An event pushed into an empty FIFO at edge N is visible with TraceValid=1 after edge N (latency 1 cycle).
- Output when empty: TraceReg/TraceData hold the last popped value (0 after reset). The consumer must not rely on this value.
- TraceReady while TraceValid=0: ignored.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Level is a separate counter, so full and empty are distinguished by Level.
- ClearOverflow=1: Overflow<=0 and DropCount<=0. If a drop occurs in the same cycle, the drop wins: Overflow<=1 and DropCount<=1.
- Stream rule: once TraceValid=1, the head entry and TraceValid stay stable until popped. Entries are never reordered.

Optional Feature:
- Macro: WB_TRACE_PC_EN.
- Defined:
  - Adds input PCW (32 bits, PC of the writing instruction) and output TracePC (32 bits).
  - Each entry widens to 69 bits; TracePC follows the same timing as TraceData.
  - TracePC resets to 0.
- Undefined: both ports and the PC storage are absent; entries are 37 bits.

Decomposition:
- Package wb_trace_pkg:
  - REG_W=5, DATA_W=32, PC_W=32.
  - Entry struct/width constants for both macro settings.
  - Default DEPTH.
- Sub-module wb_trace_fifo: generic FWFT synchronous FIFO with push, pop, full, empty and level. wb_trace_buffer adds event filtering, counters and overflow logic around it.

Test Plan:
- Reset mid-stream: 5 events pushed, Reset low for 1 ns asynchronously mid-cycle. Required: Level=0, TraceValid=0 and both counters 0 immediately, with no clock edge needed.
- Single event: RegWriteW=1, WriteRegW=8, WriteDataW=32'h0000_0005, TraceReady=0. Required after the next edge: TraceValid=1, TraceReg=8, TraceData=5, Level=1, EventCount=1.
- $0 filter: RegWriteW=1, WriteRegW=0, WriteDataW=32'hDEAD_BEEF. Required: Level, EventCount and DropCount all unchanged.
- Fill and overflow (DEPTH=16): 18 consecutive events with regs 1..18 and data=reg*3, TraceReady=0. Required: Level=16, Overflow=1, DropCount=2, EventCount=16. Draining with TraceReady=1 then yields regs 1..16 in order, data 3..48.
- Full with simultaneous push and pop: FIFO full, one event (reg 20, data 32'h14) with TraceReady=1. Required: Level stays 16, DropCount unchanged, and reg 20 is the last entry drained.
- Clear versus drop: FIFO full, ClearOverflow=1, plus an event with TraceReady=0 in the same cycle. Required: Overflow=1, DropCount=1.
